nios2_gpio_port: RTL

Parametrised general-purpose I/O port on the Nios II Avalon-MM bus. It is the successor to the fixed 16-bit output-only PIO used for SRAM-side control. It adds configurable width, per-bit direction, atomic set/clear writes, input synchronisation, edge capture, and a maskable interrupt. One instance sits per external pin group (game buttons, LEDs, SRAM control strobes), with `irq` routed to the Nios II interrupt controller.

---
 rtl/nios2_gpio_port.sv | 120 ++++++++++++
 1 files changed

// File: rtl/nios2_gpio_port.sv
// Avalon-MM general-purpose I/O port: per-bit direction, atomic set/clear,
// synchronised inputs with edge capture and a maskable interrupt.
module nios2_gpio_port #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] rd_val;
  logic             unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign wdata            = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    clr        = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_out_d = wdata;
        ADDR_DIR:      dir_d      = wdata;
        ADDR_MASK:     mask_d     = wdata;
        ADDR_EDGECAP:  clr        = wdata;
        ADDR_OUTSET:   data_out_d = data_out_q | wdata;
        ADDR_OUTCLEAR: data_out_d = data_out_q & ~wdata;
        default:       ;
      endcase
    end
  end

  // A new edge overrides a simultaneous software clear of the same bit.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = sync2_q & ~prev_q;
      1:       edge_det = ~sync2_q & prev_q;
      default: edge_det = sync2_q ^ prev_q;
    endcase
    edgecap_d = (edgecap_q & ~clr) | edge_det;
    sync1_d   = in_port;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:    rd_val = (dir_q & data_out_q) | (~dir_q & sync2_q);
      ADDR_DIR:     rd_val = dir_q;
      ADDR_MASK:    rd_val = mask_q;
      ADDR_EDGECAP: rd_val = edgecap_q;
      default:      rd_val = '0;
    endcase
    readdata             = '0;
    readdata[WIDTH-1:0]  = rd_val;
  end

  always_comb begin
    if (IRQ_MODE == 0) irq = |(sync2_q & mask_q);
    else               irq = |(edgecap_q & mask_q);
  end

  assign out_port = data_out_q;
  assign oe_port  = dir_q;

endmodule
